// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side drain engine.
package fifo_rd_pkg;

   typedef enum logic [0:0] {
      RUN,
      FLUSH
   } rd_state_t;

   // Occupancy of the 2-entry output buffer needs values 0..2.
   localparam int unsigned OCC_W      = 2;
   localparam int unsigned CNT_W_DFLT = 16;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Downstream valid/ready stream carrying drained FIFO words.
interface fifo_rd_stream_if #(
   parameter int unsigned DSIZE = 8
);
   logic [DSIZE-1:0] m_data;
   logic             m_valid;
   logic             m_ready;

   modport master (
      output m_data,
      output m_valid,
      input  m_ready
   );

   modport slave (
      input  m_data,
      input  m_valid,
      output m_ready
   );
endinterface

// File: rtl/rd_skid_buf.sv
// Two-entry output buffer: head drives the stream, tail absorbs one word of backpressure.
module rd_skid_buf
   import fifo_rd_pkg::*;
#(
   parameter int unsigned DSIZE = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic [DSIZE-1:0] push_data,
   input  logic             pop,
   output logic [DSIZE-1:0] head_data,
   output logic             head_valid,
   output logic [OCC_W-1:0] occ
);

   logic [DSIZE-1:0] head_q, head_d;
   logic [DSIZE-1:0] tail_q, tail_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             pop_eff;
   logic             push_eff;

   // Ignore a pop on an empty buffer and a push that would overrun it.
   assign pop_eff  = pop && (occ_q != '0);
   assign push_eff = push && ((occ_q != OCC_W'(2)) || pop_eff);

   // Next-state: entries shift toward the head on pop; new data lands in the first free slot.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      if (clr) begin
         occ_d = '0;
      end else begin
         case ({push_eff, pop_eff})
            2'b10: begin
               if (occ_q == '0) head_d = push_data;
               else             tail_d = push_data;
               occ_d = occ_q + OCC_W'(1);
            end
            2'b01: begin
               head_d = tail_q;
               occ_d  = occ_q - OCC_W'(1);
            end
            2'b11: begin
               // Occupancy holds; the incoming word replaces the retired one in order.
               if (occ_q == OCC_W'(1)) begin
                  head_d = push_data;
               end else begin
                  head_d = tail_q;
                  tail_d = push_data;
               end
            end
            default: ;
         endcase
      end
   end

   // Buffer storage and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   assign head_data  = head_q;
   assign head_valid = (occ_q != '0);
   assign occ        = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain drain engine: pops an FWFT FIFO into a registered valid/ready stream,
// counts delivered words and supports a flush that discards buffered and queued data.
module fifo_rd_stream
   import fifo_rd_pkg::*;
#(
   parameter int unsigned DSIZE = 8,
   parameter int unsigned CNT_W = CNT_W_DFLT
) (
   input  logic               rclk,
   input  logic               rrst_n,
   input  logic [DSIZE-1:0]   rdata,
   input  logic               rempty,
   output logic               rinc,
   input  logic               flush,
   fifo_rd_stream_if.master   m_if,
   output logic               flushing,
   output logic [CNT_W-1:0]   word_cnt
);

   rd_state_t        state_q, state_d;
   logic [OCC_W-1:0] occ;
   logic             buf_push;
   logic             buf_clr;
   logic             hs;
   logic [CNT_W-1:0] word_cnt_q;

   assign hs = m_if.m_valid && m_if.m_ready;

   rd_skid_buf #(
      .DSIZE (DSIZE)
   ) u_buf (
      .clk        (rclk),
      .rst_n      (rrst_n),
      .clr        (buf_clr),
      .push       (buf_push),
      .push_data  (rdata),
      .pop        (hs),
      .head_data  (m_if.m_data),
      .head_valid (m_if.m_valid),
      .occ        (occ)
   );

   // State register.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) state_q <= RUN;
      else         state_q <= state_d;
   end

   // Next state: flush request enters FLUSH, an empty FIFO returns to RUN.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:   if (flush)  state_d = FLUSH;
         FLUSH: if (rempty) state_d = RUN;
      endcase
   end

   // Outputs: rinc depends only on registered occupancy and rempty, never on m_ready.
   always_comb begin
      rinc     = 1'b0;
      buf_push = 1'b0;
      buf_clr  = 1'b0;
      flushing = 1'b0;
      unique case (state_q)
         RUN: begin
            rinc     = !rempty && (occ < OCC_W'(2));
            buf_push = rinc && !flush;
            buf_clr  = flush;
         end
         FLUSH: begin
            rinc     = !rempty;
            flushing = 1'b1;
         end
      endcase
   end

   // Delivered-word counter; wraps naturally and survives flushes.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n)  word_cnt_q <= '0;
      else if (hs)  word_cnt_q <= word_cnt_q + CNT_W'(1);
   end

   assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: an FWFT FIFO and the expected output buffer are kept as queues.
module tb_fifo_rd_stream;

   logic        rclk;
   logic        rrst_n;
   logic [7:0]  rdata;
   logic        rempty;
   logic        rinc;
   logic        flush;
   logic        flushing;
   logic [15:0] word_cnt;

   fifo_rd_stream_if #(.DSIZE(8)) m_if ();

   fifo_rd_stream #(
      .DSIZE (8),
      .CNT_W (16)
   ) dut (
      .rclk     (rclk),
      .rrst_n   (rrst_n),
      .rdata    (rdata),
      .rempty   (rempty),
      .rinc     (rinc),
      .flush    (flush),
      .m_if     (m_if),
      .flushing (flushing),
      .word_cnt (word_cnt)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   bit [7:0]    q[$];    // FIFO contents
   bit [7:0]    mq[$];   // words expected in the output buffer, head first
   bit          run;
   logic [15:0] exp_cnt;
   int          hs_total;
   int          delivered;
   int          discards;
   int          errors;
   int          checks;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_fifo();
      rempty = (q.size() == 0);
      rdata  = rempty ? 8'h00 : q[0];
   endtask

   task automatic push(input bit [7:0] w);
      q.push_back(w);
      set_fifo();
   endtask

   // One read-clock cycle: check outputs against the model, take the edge, advance the model.
   task automatic cycle();
      bit pop, hs, fl, emp, exp_rinc, exp_valid;
      #1;
      exp_valid = run && (mq.size() != 0);
      exp_rinc  = run ? ((q.size() != 0) && (mq.size() < 2)) : (q.size() != 0);
      chk("rinc", rinc, exp_rinc);
      chk("m_valid", m_if.m_valid, exp_valid);
      if (exp_valid) chk("m_data", m_if.m_data, mq[0]);
      chk("flushing", flushing, !run);
      chk("word_cnt", word_cnt, exp_cnt);
      pop = rinc;
      hs  = exp_valid && m_if.m_ready;
      fl  = flush;
      emp = rempty;
      @(posedge rclk);
      #1;
      if (run) begin
         if (hs) begin
            void'(mq.pop_front());
            exp_cnt++;
            hs_total++;
            delivered++;
         end
         if (fl) begin
            mq.delete();
            run = 1'b0;
         end else if (pop && q.size() != 0) begin
            mq.push_back(q[0]);
         end
      end else begin
         if (pop) discards++;
         if (emp) run = 1'b1;
      end
      if (pop && q.size() != 0) void'(q.pop_front());
      flush = 1'b0;
      set_fifo();
   endtask

   initial begin
      int budget;
      int sent;
      errors    = 0;
      checks    = 0;
      run       = 1'b1;
      exp_cnt   = '0;
      hs_total  = 0;
      delivered = 0;
      discards  = 0;
      rrst_n    = 1'b0;
      flush     = 1'b0;
      m_if.m_ready = 1'b0;
      set_fifo();

      // Reset state
      #12;
      chk("rst_m_valid", m_if.m_valid, 1'b0);
      chk("rst_m_data", m_if.m_data, 8'h00);
      chk("rst_word_cnt", word_cnt, 16'd0);
      chk("rst_flushing", flushing, 1'b0);
      chk("rst_rinc", rinc, 1'b0);
      @(posedge rclk);
      #1;
      rrst_n = 1'b1;

      // Three words streamed with m_ready high
      push(8'h11);
      push(8'h22);
      push(8'h33);
      m_if.m_ready = 1'b1;
      repeat (6) cycle();
      chk("t1_word_cnt", word_cnt, 16'd3);

      // Backpressure: five queued, only two popped, head held
      m_if.m_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
      repeat (6) cycle();
      chk("t2_fifo_left", q.size(), 3);
      chk("t2_head_hold", m_if.m_data, 8'h50);
      m_if.m_ready = 1'b1;
      repeat (8) cycle();
      chk("t2_word_cnt", word_cnt, 16'd8);

      // Random data and random backpressure
      delivered = 0;
      sent      = 0;
      budget    = 0;
      while (delivered < 64 && budget < 3000) begin
         int n;
         n = $urandom_range(0, 3);
         for (int k = 0; k < n && sent < 64; k++) begin
            push(8'($urandom));
            sent++;
         end
         m_if.m_ready = 1'($urandom_range(0, 1));
         cycle();
         budget++;
      end
      chk("rand_delivered", delivered, 64);
      chk("rand_word_cnt", word_cnt, 16'd72);

      // Flush with a full buffer and six words still queued
      m_if.m_ready = 1'b0;
      for (int i = 0; i < 8; i++) push(8'h60 + 8'(i));
      repeat (3) cycle();
      chk("fl_fifo_left", q.size(), 6);
      discards = 0;
      flush    = 1'b1;
      cycle();
      budget = 0;
      while (!run && budget < 20) begin
         cycle();
         budget++;
      end
      chk("fl_returned_run", run, 1'b1);
      chk("fl_discards", discards, 6);
      chk("fl_word_cnt", word_cnt, 16'd72);
      push(8'hA5);
      m_if.m_ready = 1'b1;
      repeat (4) cycle();
      chk("fl_new_word_cnt", word_cnt, 16'd73);

      // Counter wrap at 2^16 handshakes
      budget = 0;
      while (hs_total < 65535 && budget < 70000) begin
         if (q.size() < 3) push(8'($urandom));
         cycle();
         budget++;
      end
      chk("wrap_hs_total", hs_total, 65535);
      chk("wrap_max", word_cnt, 16'hFFFF);
      budget = 0;
      while (hs_total < 65536 && budget < 10) begin
         if (q.size() < 3) push(8'($urandom));
         cycle();
         budget++;
      end
      chk("wrap_zero", word_cnt, 16'd0);

      // Asynchronous reset with a full buffer
      m_if.m_ready = 1'b0;
      q.delete();
      push(8'hC1);
      push(8'hC2);
      push(8'hC3);
      repeat (3) cycle();
      chk("ar_pre_valid", m_if.m_valid, 1'b1);
      #2;
      rrst_n = 1'b0;
      #1;
      chk("ar_m_valid", m_if.m_valid, 1'b0);
      chk("ar_m_data", m_if.m_data, 8'h00);
      chk("ar_word_cnt", word_cnt, 16'd0);
      chk("ar_flushing", flushing, 1'b0);
      q.delete();
      set_fifo();
      #1;
      chk("ar_rinc", rinc, 1'b0);
      mq.delete();
      run     = 1'b1;
      exp_cnt = '0;
      @(posedge rclk);
      #1;
      rrst_n = 1'b1;
      push(8'h3C);
      m_if.m_ready = 1'b1;
      repeat (4) cycle();
      chk("ar_post_word_cnt", word_cnt, 16'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain engine for `async_fifo`, running entirely in the read clock domain. It pops words from the FIFO read port (`rinc`/`rdata`/`rempty`) and presents them downstream as a registered valid/ready stream through a 2-entry output buffer. It also counts delivered words and supports a synchronous flush that discards buffered and queued data. Instantiated next to every `async_fifo` whose consumer needs backpressure instead of raw pop strobes.

## Interface
- `DSIZE`, 8, data width; must match the FIFO's `DSIZE`.
- `CNT_W`, 16, width of the delivered-word counter.

- `rclk` in 1: read-domain clock, shared with the FIFO read side.
- `rrst_n` in 1: reset, asynchronous, active-low.
- `rdata` in DSIZE: FIFO read data. First-word-fall-through: valid combinationally whenever `rempty`=0.
- `rempty` in 1: FIFO empty flag.
- `rinc` out 1: FIFO pop. The FIFO pops on the `rclk` edge where `rinc`=1.
- `flush` in 1: single-cycle request to discard all pending data.
- `m_data` out DSIZE: downstream data, registered.
- `m_valid` out 1: downstream valid, registered.
- `m_ready` in 1: downstream ready.
- `flushing` out 1: high while in state FLUSH.
- `word_cnt` out CNT_W: count of completed downstream handshakes.

## Operation
- Buffer occupancy `occ` ∈ {0,1,2}. `m_data` and `m_valid` always reflect the head entry; `m_valid` = (`occ`≠0).
- Handshake: `m_valid && m_ready` at a rising edge. This retires the head; the second entry, if present, becomes head at the same edge.
- State machine, states RUN and FLUSH. Reset enters RUN.
- In RUN:
  - `rinc` = !`rempty` && (`occ`<2).
  - `rinc` is combinational from registered `occ` and `rempty` only; there is no path from `m_ready` to `rinc`.
  - On an edge with `rinc`=1, `rdata` is written into the buffer tail.
- Occupancy update: `occ_next` = `occ` + `rinc` − handshake. A simultaneous pop and handshake at `occ`=1 holds `occ`=1 with the new head.
- `m_data` and `m_valid` stay stable while `m_valid`=1 and `m_ready`=0.
- `flush`=1 in RUN:
  - A handshake in that same cycle still completes and counts.
  - Next cycle: state FLUSH, `occ`=0, `m_valid`=0.
  - Any pop in the flush cycle is discarded.
- In FLUSH:
  - `rinc` = !`rempty`; popped data is discarded.
  - `m_valid`=0; `flushing`=1.
  - `flush` is ignored.
  - Return to RUN at the edge where `rempty`=1 is sampled.
- `word_cnt` increments by 1 per handshake, modulo 2^CNT_W (wraps to 0). Discards never count. Flush does not clear it.
- Reset mid-operation clears state immediately. FIFO contents are not touched.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `word_cnt`=0, `flushing`=0, `occ`=0, state RUN. `rinc` is 0 whenever `rempty`=1.
- Latency: word W is popped at edge N (`rinc`=1). `m_valid`=1 with `m_data`=W is visible after edge N, i.e. in cycle N+1.
- Throughput: 1 word/cycle sustained when `rempty`=0 and `m_ready`=1.
- Full buffer (`occ`=2) with `m_ready`=0: `rinc`=0; no FIFO underflow or overrun.
- Flush latency: `flushing` rises 1 cycle after the `flush` pulse. It falls 1 cycle after `rempty`=1 is sampled in FLUSH.
- Words written into the FIFO after flush completes are delivered normally.

## Structure
- Package `fifo_rd_pkg`:
  - state enum `rd_state_t` {RUN, FLUSH};
  - occupancy width constant `OCC_W`=2;
  - default `CNT_W`.
- Sub-module `rd_skid_buf`: 2-entry buffer with `occ`, push, pop, head output, and clear. Parameterised by DSIZE.
- The top level holds the FSM, `rinc` logic and `word_cnt`.

## Test plan
- Reset, then FIFO with 3 words (0x11,0x22,0x33), `m_ready`=1 → `m_valid` rises 1 cycle after the first `rinc`; data 0x11,0x22,0x33 on consecutive cycles; `word_cnt`=3.
- 5 words queued, `m_ready`=0 → exactly 2 pops, `rinc`=0 thereafter, `m_data`=word0 held stable. Raise `m_ready` → all 5 delivered in order.
- Random `m_ready` (50%), 64 random words through `async_fifo` with `wclk` 20 ns / `rclk` 70 ns → scoreboard matches every word in order, `word_cnt`=64.
- `flush` pulse with `occ`=2 and 6 words in the FIFO, `m_ready`=0 → `m_valid`=0 next cycle, `flushing`=1, 6 discard pops, then RUN. A new word 0xA5 is delivered next; `word_cnt` unchanged by the discards.
- `word_cnt` preset via 65535 handshakes (CNT_W=16), one more handshake → `word_cnt`=0.
- `rrst_n` asserted while `occ`=2 and `m_valid`=1 → all outputs reset immediately (asynchronously), `rinc`=0 while `rempty`=1.
